ahbl_arbiter: RTL
=================

Name: ahbl_arbiter

Overview:
- N-to-1 AHB-Lite arbiter: N upstream masters share one downstream AHB-Lite slave port.
- Sits in front of a shared slave, e.g. one SRAM behind a crossbar slave port.
- Selects one master's address phase per transfer using round-robin priority.
- Stalls losing masters with hready low, and routes data-phase responses and read data back to the owning master.

Parameters:
- N_PORTS, 4, number of upstream masters (2..8).
- W_ADDR, 32, address width.
- W_DATA, 32, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- src_hready_resp  out  N_PORTS  per-master hready.
- src_hresp  out  N_PORTS  per-master hresp.
- src_haddr  in  N_PORTS*W_ADDR  packed; port k at [k*W_ADDR +: W_ADDR].
- src_hwrite  in  N_PORTS
- src_htrans  in  2*N_PORTS
- src_hsize  in  3*N_PORTS
- src_hburst  in  3*N_PORTS
- src_hprot  in  4*N_PORTS
- src_hmastlock  in  N_PORTS
- src_hwdata  in  N_PORTS*W_DATA
- src_hrdata  out  N_PORTS*W_DATA  dst_hrdata broadcast to all ports.
- dst_hready  out  1  equals dst_hready_resp.
- dst_hready_resp  in  1  slave hreadyout.
- dst_hresp  in  1
- dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock  out  (same widths as one src port)  address phase of the granted master.
- dst_hwdata  out  W_DATA  hwdata of the data-phase owner.
- dst_hrdata  in  W_DATA

Behaviour:
- req[k] = src_htrans[k][1] (NSEQ or SEQ) and port k is not currently the data-phase owner with dst_hready_resp low.
- Grant is combinational.
  - When dst_hready_resp=1, the grant goes to the first requesting port at or after rr_ptr, wrapping modulo N_PORTS.
  - If no port requests, there is no grant and dst_htrans=IDLE.
- Lock: if the previously granted port held src_hmastlock=1 and still requests, it keeps the grant regardless of rr_ptr.
- Address outputs are a zero-latency mux of the granted port. With no grant, dst_htrans=2'b00 and the other address fields come from the last granted port.
- Registers update only on cycles with dst_hready_resp=1:
  - data_owner <= grant, with a valid bit.
  - rr_ptr <= (granted index + 1) mod N_PORTS when a grant occurs. rr_ptr holds while locked.
  - last_grant <= grant.
- dst_hwdata muxes from data_owner; it is 0 when no data phase is valid.
- src_hready_resp[k]:
  - If k is the data-phase owner: dst_hready_resp.
  - Else if req[k] and k is not granted this cycle: 0 (address phase stalled; the master holds its address stable).
  - Else if req[k] and granted: dst_hready_resp.
  - Otherwise: 1.
- src_hresp[k] = dst_hresp when k is the data owner, else 0.
- Error response: both cycles of a two-cycle ERROR go to the owner. On the first cycle (dst_hready_resp=0, dst_hresp=1) the grant is still evaluated normally. A master that changes htrans to IDLE in response simply stops requesting.
- Back-to-back: the same master may be granted on consecutive transfers only if no other port requests or it is locked.
- Reset: rr_ptr=0, data_owner valid=0, last_grant=port 0, lock=0. Output values while rst is high:
  - All src_hready_resp=1 and src_hresp=0.
  - dst_htrans is forced to IDLE.
- Reset mid-transfer: an in-flight data phase is abandoned and no response is routed after reset.
- The slave does not see a partial transfer beyond the current cycle, since dst_htrans is forced IDLE while rst=1.
- Throughput: one transfer per cycle with a zero-wait slave. Arbitration adds no latency.

Test Plan:
- Single master: port 2 writes 0xA5 to 0x0000_0012, then reads it back. Required: dst_haddr=0x12 in the same cycle; rdata returned is 0xA5; other ports see hready=1 throughout.
- Collision: ports 0 and 1 both issue NSEQ in the same cycle with rr_ptr=0. Required: port 0 is granted first and port 1 sees hready=0 for 1 cycle; port 1 is granted next cycle with its address unchanged; rr_ptr ends at 2.
- Fairness: all 4 ports request continuously for 16 transfers. Required: grant order 0,1,2,3,0,1,2,3,… with exactly 4 grants each.
- Slave wait states: slave holds hreadyout=0 for 3 cycles during port 3's data phase. Required: port 3 and all stalled requesters see hready=0 for those 3 cycles; no grant change occurs.
- Error and lock:
  - Slave returns ERROR to port 1. Required: port 1 sees hresp=1 for 2 cycles, with hready 0 then 1; other ports see hresp=0.
  - Port 0 asserts hmastlock for 3 transfers while port 2 requests. Required: port 0 gets 3 consecutive grants, then port 2 is granted.
- Reset and randomized traffic:
  - Assert rst during port 1's data phase. Required: the next cycle has all src_hready_resp=1, dst_htrans=IDLE and rr_ptr=0.
  - Then run the 4-master randomized byte write/readback stress of 64 bytes per master, with interleaved addresses k+4i. Required: all readbacks match.

Source files
------------

// File: rtl/ahbl_arbiter.sv
// ---------------------------------------------------------------------------
// ahbl_arbiter
//   N-to-1 AHB-Lite arbiter. N_PORTS upstream masters share one downstream
//   AHB-Lite slave port. One master's address phase is selected per transfer
//   with round-robin priority, with a hold-over for locked sequences. Losing
//   masters are stalled with hready low. The data-phase response, write data
//   and read data are routed by the registered data-phase owner.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   src_*               packed per-master AHB-Lite master-side signals,
//                       port k occupies slice [k*W +: W] of each bus
//   src_hready_resp/o   per-master hready, src_hresp per-master hresp
//   src_hrdata          dst_hrdata broadcast to every port
//   dst_*               shared slave port; address fields are a zero-latency
//                       mux of the granted master, dst_hwdata follows the
//                       data-phase owner
// ---------------------------------------------------------------------------
module ahbl_arbiter #(
    parameter int N_PORTS = 4,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [N_PORTS-1:0]          src_hready_resp,
    output logic [N_PORTS-1:0]          src_hresp,
    input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
    input  logic [N_PORTS-1:0]          src_hwrite,
    input  logic [2*N_PORTS-1:0]        src_htrans,
    input  logic [3*N_PORTS-1:0]        src_hsize,
    input  logic [3*N_PORTS-1:0]        src_hburst,
    input  logic [4*N_PORTS-1:0]        src_hprot,
    input  logic [N_PORTS-1:0]          src_hmastlock,
    input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
    output logic [N_PORTS*W_DATA-1:0]   src_hrdata,
    output logic                        dst_hready,
    input  logic                        dst_hready_resp,
    input  logic                        dst_hresp,
    output logic [W_ADDR-1:0]           dst_haddr,
    output logic                        dst_hwrite,
    output logic [1:0]                  dst_htrans,
    output logic [2:0]                  dst_hsize,
    output logic [2:0]                  dst_hburst,
    output logic [3:0]                  dst_hprot,
    output logic                        dst_hmastlock,
    output logic [W_DATA-1:0]           dst_hwdata,
    input  logic [W_DATA-1:0]           dst_hrdata
);

    localparam int IDX_W = $clog2(N_PORTS);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   cnt_t;

    // Successor of a port index in the round-robin ring.
    function automatic idx_t next_idx(input idx_t idx);
        if (idx == idx_t'(N_PORTS - 1)) begin
            return '0;
        end else begin
            return idx + idx_t'(1);
        end
    endfunction

    idx_t   rr_ptr_q,     rr_ptr_d;
    idx_t   owner_q,      owner_d;
    logic   owner_vld_q,  owner_vld_d;
    idx_t   last_grant_q, last_grant_d;
    logic   lock_q,       lock_d;

    logic [N_PORTS-1:0] req_s;
    logic               grant_vld_s;
    idx_t               grant_idx_s;
    logic               grant_by_lock_s;
    idx_t               sel_idx_s;
    cnt_t               cand_s;

    // Request vector: a NSEQ/SEQ master, except the owner of a stalled data phase.
    always_comb begin
        req_s = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (owner_vld_q && (owner_q == idx_t'(k)) && !dst_hready_resp) begin
                req_s[k] = 1'b0;
            end else begin
                req_s[k] = src_htrans[2*k+1];
            end
        end
    end

    // Grant: locked master keeps the bus, otherwise first requester at/after rr_ptr.
    always_comb begin
        grant_vld_s     = 1'b0;
        grant_idx_s     = rr_ptr_q;
        grant_by_lock_s = 1'b0;
        cand_s          = '0;
        if (lock_q && req_s[last_grant_q]) begin
            grant_vld_s     = 1'b1;
            grant_idx_s     = last_grant_q;
            grant_by_lock_s = 1'b1;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                cand_s = {1'b0, rr_ptr_q} + cnt_t'(i);
                if (cand_s >= cnt_t'(N_PORTS)) begin
                    cand_s = cand_s - cnt_t'(N_PORTS);
                end else begin
                    cand_s = cand_s;
                end
                if (!grant_vld_s && req_s[cand_s[IDX_W-1:0]]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_s[IDX_W-1:0];
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
    end

    // Address mux source: the granted port, or the last granted port when idle.
    always_comb begin
        if (grant_vld_s) begin
            sel_idx_s = grant_idx_s;
        end else begin
            sel_idx_s = last_grant_q;
        end
    end

    assign dst_haddr     = src_haddr[sel_idx_s*W_ADDR +: W_ADDR];
    assign dst_hwrite    = src_hwrite[sel_idx_s];
    assign dst_hsize     = src_hsize[sel_idx_s*3 +: 3];
    assign dst_hburst    = src_hburst[sel_idx_s*3 +: 3];
    assign dst_hprot     = src_hprot[sel_idx_s*4 +: 4];
    assign dst_hmastlock = src_hmastlock[sel_idx_s];
    // Reset forces IDLE so the slave never sees a transfer start during reset.
    assign dst_htrans    = (grant_vld_s && !rst) ? src_htrans[sel_idx_s*2 +: 2] : 2'b00;
    assign dst_hwdata    = owner_vld_q ? src_hwdata[owner_q*W_DATA +: W_DATA] : '0;
    assign dst_hready    = dst_hready_resp;
    assign src_hrdata    = {N_PORTS{dst_hrdata}};

    // Per-master hready/hresp: owner sees the slave, stalled requesters see 0.
    always_comb begin
        src_hready_resp = '1;
        src_hresp       = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (rst) begin
                src_hready_resp[k] = 1'b1;
                src_hresp[k]       = 1'b0;
            end else if (owner_vld_q && (owner_q == idx_t'(k))) begin
                src_hready_resp[k] = dst_hready_resp;
                src_hresp[k]       = dst_hresp;
            end else if (req_s[k] && !(grant_vld_s && (grant_idx_s == idx_t'(k)))) begin
                src_hready_resp[k] = 1'b0;
                src_hresp[k]       = 1'b0;
            end else if (req_s[k]) begin
                src_hready_resp[k] = dst_hready_resp;
                src_hresp[k]       = 1'b0;
            end else begin
                src_hready_resp[k] = 1'b1;
                src_hresp[k]       = 1'b0;
            end
        end
    end

    // Next state: arbitration state advances only when the slave completes a cycle.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        owner_vld_d  = owner_vld_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        if (dst_hready_resp) begin
            owner_vld_d = grant_vld_s;
            owner_d     = grant_idx_s;
            if (grant_vld_s) begin
                last_grant_d = grant_idx_s;
                lock_d       = src_hmastlock[grant_idx_s];
                // A locked continuation does not consume a round-robin turn.
                if (grant_by_lock_s) begin
                    rr_ptr_d = rr_ptr_q;
                end else begin
                    rr_ptr_d = next_idx(grant_idx_s);
                end
            end else begin
                // Lock survives idle cycles only while the holder keeps hmastlock.
                lock_d = lock_q && src_hmastlock[last_grant_q];
            end
        end else begin
            owner_vld_d = owner_vld_q;
        end
    end

    // State registers with synchronous reset; reset abandons any data phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            owner_vld_q  <= 1'b0;
            last_grant_q <= '0;
            lock_q       <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            owner_vld_q  <= owner_vld_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
        end
    end

endmodule
